// File: rtl/sync_frame_serializer_if.sv
// Handshake and serial-stream bundle between a word producer, the serializer and the serial consumer.
// Latency: none (wires only).
// Backpressure: data_ready from the serializer stalls the producer; the serial side has no backpressure.
//
// Signals:
//   data_in    payload word, valid with data_valid
//   data_valid producer has a word on data_in
//   data_ready serializer can accept a word this cycle
//   serial_out registered serial bit stream
//   busy       frame in progress
//   frame_done one-cycle pulse in the first idle cycle after a frame
interface sync_frame_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  data_ready;
  logic                  serial_out;
  logic                  busy;
  logic                  frame_done;

  // Producer / observer side.
  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  serial_out,
    input  busy,
    input  frame_done
  );

  // Serializer side.
  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output serial_out,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/sync_frame_serializer.sv
// Frames a parallel word as SYNC_PATTERN preamble + payload (MSB first) on a single serial line.
// Latency: first preamble bit on serial_out one cycle after the accepting edge; one bit per clock after that.
// Backpressure: data_ready is high only in IDLE; a word offered while busy is ignored and must be held.
//
// Ports:
//   clk    system clock, rising-edge
//   n_rst  asynchronous active-low reset
//   bus    sync_frame_serializer_if.slave (data_in/data_valid/data_ready, serial_out, busy, frame_done)
// Optional feature: define SERIALIZER_PARITY_EN to append one even-parity bit after the payload LSB.
module sync_frame_serializer #(
  parameter int                  DATA_WIDTH   = 8,
  parameter int                  SYNC_LEN     = 4,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 4'b1101
) (
  input logic                   clk,
  input logic                   n_rst,
  sync_frame_serializer_if.slave bus
);

  localparam int MAX_LEN = (SYNC_LEN > DATA_WIDTH) ? SYNC_LEN : DATA_WIDTH;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  // Counter holds the index of the bit currently on serial_out within its field.
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;
`endif

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    serial_q, serial_d;
  logic                    done_q, done_d;

  logic [CNT_W-1:0]        cnt_m1;
  logic [SYNC_LEN-1:0]     sync_sh;
  logic [DATA_WIDTH-1:0]   data_sh;

  // State register and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic. serial_d is the bit that will be on the line during
  // the next state, so the line is a pure register with one-cycle latency.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    serial_d = 1'b0;
    done_d   = 1'b0;

    // Bit selection by shifting keeps the variable index width-clean.
    cnt_m1  = cnt_q - CNT_W'(1);
    sync_sh = SYNC_PATTERN >> cnt_m1;
    data_sh = shift_q >> cnt_m1;

    case (state_q)
      IDLE: begin
        if (bus.data_valid) begin
          state_d  = SYNC;
          cnt_d    = SYNC_LAST;
          shift_d  = bus.data_in;
          serial_d = SYNC_PATTERN[SYNC_LEN-1];
        end
      end

      SYNC: begin
        if (cnt_q == '0) begin
          state_d  = DATA;
          cnt_d    = DATA_LAST;
          serial_d = shift_q[DATA_WIDTH-1];
        end else begin
          cnt_d    = cnt_m1;
          serial_d = sync_sh[0];
        end
      end

      DATA: begin
        if (cnt_q == '0) begin
`ifdef SERIALIZER_PARITY_EN
          state_d  = PARITY;
          cnt_d    = '0;
          serial_d = ^shift_q;
`else
          state_d  = IDLE;
          cnt_d    = '0;
          done_d   = 1'b1;
`endif
        end else begin
          cnt_d    = cnt_m1;
          serial_d = data_sh[0];
        end
      end

`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs. data_ready/busy decode the state register only, so they take
  // their reset values as soon as n_rst falls.
  always_comb begin
    bus.data_ready = (state_q == IDLE);
    bus.busy       = (state_q != IDLE);
    bus.serial_out = serial_q;
    bus.frame_done = done_q;
  end

endmodule

// File: tb/tb_sync_frame_serializer.sv
// Bench for sync_frame_serializer: directed frames plus random traffic against a bit-queue model.
// Latency: n/a.
// Backpressure: producer holds data_valid until data_ready is seen.
module tb_sync_frame_serializer;

  localparam int DW = 8;
  localparam int SL = 4;
  localparam logic [SL-1:0] PAT = 4'b1101;

`ifdef SERIALIZER_PARITY_EN
  localparam int FLEN = SL + DW + 1;
  localparam logic [31:0] EXP_A5  = {18'd0, 12'hDA5, 1'b0, 1'b0};
  localparam logic [31:0] EXP_01  = {18'd0, 12'hD01, 1'b1, 1'b0};
  localparam logic [31:0] EXP_3C  = {18'd0, 12'hD3C, 1'b0, 1'b0};
  localparam logic [31:0] EXP_B2B = {4'd0, 12'hDA5, 1'b0, 1'b0, 12'hD0F, 1'b0, 1'b0};
`else
  localparam int FLEN = SL + DW;
  localparam logic [31:0] EXP_A5  = {19'd0, 12'hDA5, 1'b0};
  localparam logic [31:0] EXP_01  = {19'd0, 12'hD01, 1'b0};
  localparam logic [31:0] EXP_3C  = {19'd0, 12'hD3C, 1'b0};
  localparam logic [31:0] EXP_B2B = {6'd0, 12'hDA5, 1'b0, 12'hD0F, 1'b0};
`endif

  logic clk;
  logic n_rst;

  sync_frame_serializer_if #(.DATA_WIDTH(DW)) sif ();

  sync_frame_serializer #(
    .DATA_WIDTH  (DW),
    .SYNC_LEN    (SL),
    .SYNC_PATTERN(PAT)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (sif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: every accepted word becomes a list of line bits; the
  // line shows one queued bit per cycle, 0 when the queue is empty.
  bit   exp_q[$];
  logic m_serial, m_busy, m_done, m_ready;

  task automatic push_frame(input logic [DW-1:0] w);
    for (int i = SL - 1; i >= 0; i--) exp_q.push_back(PAT[i]);
    for (int i = DW - 1; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef SERIALIZER_PARITY_EN
    exp_q.push_back(^w);
`endif
  endtask

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      exp_q.delete();
      m_serial = 1'b0;
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_ready  = 1'b1;
    end else begin
      if (m_ready && sif.data_valid) push_frame(sif.data_in);
      if (exp_q.size() > 0) begin
        m_done   = 1'b0;
        m_serial = exp_q.pop_front();
        m_busy   = 1'b1;
      end else begin
        m_done   = m_busy;
        m_serial = 1'b0;
        m_busy   = 1'b0;
      end
      m_ready = !m_busy;
    end
  end

  always @(negedge clk) begin
    check_eq("serial_out", 32'(sif.serial_out), 32'(m_serial));
    check_eq("busy",       32'(sif.busy),       32'(m_busy));
    check_eq("frame_done", 32'(sif.frame_done), 32'(m_done));
    check_eq("data_ready", 32'(sif.data_ready), 32'(m_ready));
  end

  // Line recorder for directed frames.
  logic [31:0] rec;
  int          rec_n;
  int          busy_cnt;
  int          done_at;
  bit          rec_en;

  always @(negedge clk) begin
    if (rec_en) begin
      rec = {rec[30:0], sif.serial_out};
      rec_n++;
      if (sif.busy) busy_cnt++;
      if (sif.frame_done) done_at = rec_n;
    end
  end

  task automatic rec_start();
    rec      = '0;
    rec_n    = 0;
    busy_cnt = 0;
    done_at  = 0;
    rec_en   = 1'b1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!sif.data_ready && n < 64) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!sif.data_ready) check_eq("hs_timeout", 32'(sif.data_ready), 32'd1);
  endtask

  task automatic wait_rec(input int n);
    int k = 0;
    while (rec_n < n && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (rec_n < n) check_eq("rec_timeout", 32'(rec_n), 32'(n));
    rec_en = 1'b0;
  endtask

  // Offers w, completes the handshake, then scrambles data_in to show it is not re-sampled.
  task automatic send_frame(input logic [DW-1:0] w);
    @(negedge clk);
    #1;
    sif.data_in    = w;
    sif.data_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1;
    rec_start();
    sif.data_valid = 1'b0;
    sif.data_in    = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_serial"}, 32'(sif.serial_out), 32'd0);
    check_eq({tag, "_busy"},   32'(sif.busy),       32'd0);
    check_eq({tag, "_done"},   32'(sif.frame_done), 32'd0);
    check_eq({tag, "_ready"},  32'(sif.data_ready), 32'd1);
  endtask

  initial begin
    n_rst          = 1'b0;
    rec_en         = 1'b0;
    sif.data_valid = 1'b0;
    sif.data_in    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;

    // Reset asserted in the clock high phase, observed before the next edge.
    @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check_idle_outputs("rst_imm");
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("rst_hold");
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("rst_rel");

    // Single frame, with data_in changed right after the handshake.
    send_frame(8'hA5);
    wait_rec(FLEN + 1);
    check_eq("a5_bits", rec, EXP_A5);
    check_eq("a5_busy", 32'(busy_cnt), 32'(FLEN));
    check_eq("a5_done", 32'(done_at), 32'(FLEN + 1));

    // Parity-sensitive payload.
    send_frame(8'h01);
    wait_rec(FLEN + 1);
    check_eq("01_bits", rec, EXP_01);
    check_eq("01_busy", 32'(busy_cnt), 32'(FLEN));

    // Back-to-back: second word held valid throughout the first frame.
    @(negedge clk);
    #1;
    sif.data_in    = 8'hA5;
    sif.data_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1;
    rec_start();
    sif.data_in = 8'h0F;
    #1;
    wait_ready();
    @(posedge clk);
    #1;
    sif.data_valid = 1'b0;
    wait_rec(2 * FLEN + 2);
    check_eq("b2b_bits", rec, EXP_B2B);
    check_eq("b2b_busy", 32'(busy_cnt), 32'(2 * FLEN));
    check_eq("b2b_done", 32'(done_at), 32'(2 * FLEN + 2));

    // Mid-frame reset after 6 bits of 8'hFF, then a clean 8'h3C frame.
    send_frame(8'hFF);
    wait_rec(6);
    @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    send_frame(8'h3C);
    wait_rec(FLEN + 1);
    check_eq("3c_bits", rec, EXP_3C);
    check_eq("3c_busy", 32'(busy_cnt), 32'(FLEN));
    check_eq("3c_done", 32'(done_at), 32'(FLEN + 1));

    // Random producer: valid toggles freely, including while the serializer is busy.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      #1;
      sif.data_valid = ($urandom_range(0, 2) == 0);
      sif.data_in    = DW'($urandom);
    end
    @(negedge clk);
    #1;
    sif.data_valid = 1'b0;
    repeat (FLEN + 4) @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_frame_serializer.md
Name: sync_frame_serializer

Overview:
- Parallel-to-serial framing stage directly upstream of the 1101 Moore sequence detector.
- Accepts one DATA_WIDTH word per valid/ready handshake.
- Emits the word one bit per clock, MSB first, preceded by the SYNC_PATTERN preamble (default 1101) so the downstream detector can find frame starts.
- serial_out connects to the detector's serial input i.

Parameters:
- DATA_WIDTH, 8, payload bits per frame (legal 2..32).
- SYNC_LEN, 4, preamble length in bits (legal 1..8).
- SYNC_PATTERN, 4'b1101, preamble value; SYNC_LEN bits wide; MSB transmitted first.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- n_rst  input  1  asynchronous active-low reset.
- data_in  input  DATA_WIDTH  payload word; sampled only on handshake.
- data_valid  input  1  producer has a word on data_in.
- data_ready  output  1  serializer can accept a word this cycle.
- serial_out  output  1  registered serial bit stream.
- busy  output  1  high while a frame is being transmitted.
- frame_done  output  1  one-cycle pulse after the last bit of a frame.

Behaviour:
- One clock domain, clocked by clk; reset n_rst is asynchronous, active-low.
- While n_rst=0, outputs take their reset values immediately, independent of clk:
  - serial_out=0, busy=0, frame_done=0, data_ready=1.
  - State=IDLE; shift register and counters cleared.
- States:
  - IDLE: serial_out=0, data_ready=1, busy=0.
  - SYNC: transmits the preamble.
  - DATA: transmits the payload.
  - PARITY: present only with the optional feature.
- Handshake:
  - A transfer occurs on a rising edge where data_valid=1 and data_ready=1.
  - data_ready=1 only in IDLE.
  - data_valid while not ready has no effect and is not queued; the producer holds the word.
- On transfer:
  - data_in is captured into the shift register; later changes to data_in do not affect the frame.
  - State moves to SYNC; serial_out=SYNC_PATTERN[SYNC_LEN-1] in the cycle immediately after the accepting edge (one-cycle latency).
- Bit timing:
  - Each subsequent rising edge advances one bit.
  - SYNC sends SYNC_PATTERN MSB to LSB (SYNC_LEN cycles).
  - DATA sends the captured word MSB to LSB (DATA_WIDTH cycles).
- Counters:
  - Bit counter width is $clog2(max(SYNC_LEN,DATA_WIDTH)+1).
  - Counter reloads at each state change; no wrap-around inside a frame.
- busy=1 in every cycle where state != IDLE.
- After the final bit period:
  - The next edge returns to IDLE; serial_out=0.
  - frame_done=1 for exactly that first IDLE cycle; data_ready=1 in the same cycle.
  - A word valid in that cycle is accepted at the following edge.
  - Back-to-back frames are therefore separated by exactly one idle 0 bit.
- Reset asserted mid-frame:
  - The frame is abandoned and no frame_done is issued.
  - After release, the block sits in IDLE and the first handshake starts a clean frame.
- Frame length in bits = SYNC_LEN + DATA_WIDTH (+1 with parity).
- busy is high for exactly that many cycles per frame.

Optional Feature:
- Macro SERIALIZER_PARITY_EN.
- When defined:
  - After the DATA LSB, state PARITY transmits one even-parity bit (XOR of all captured data bits) for one cycle, then returns to IDLE.
  - Frame length grows by 1; busy and frame_done shift accordingly.
- When undefined:
  - No PARITY state, no parity logic.
  - DATA goes straight to IDLE.

Test Plan:
- Reset test: assert n_rst=0 mid-high-phase of clk -> before the next edge, serial_out=0, busy=0, frame_done=0, data_ready=1; values hold across 2 clocks in reset and after release.
- Single frame: data_in=8'hA5 with data_valid for one handshake -> serial_out=1,1,0,1,1,0,1,0,0,1,0,1 over 12 cycles, then 0; busy high exactly 12 cycles; frame_done pulses in cycle 13; downstream detector output o rises after the preamble.
- Back-to-back: hold data_valid=1 with 8'h0F during frame 1 -> data_ready=0 throughout; 8'h0F accepted at the edge ending the frame_done cycle; exactly one 0 bit between the two frames.
- Mid-frame reset: pull n_rst low after 6 transmitted bits of 8'hFF -> all outputs return to reset values immediately with no frame_done; after release, 8'h3C is framed correctly as 1101 00111100.
- Input isolation: change data_in from 8'hA5 to 8'h00 one cycle after the handshake -> the transmitted payload remains 10100101.
- Parity (macro defined): 8'h01 -> 13 bits ending in payload 00000001 then parity 1; 8'hA5 -> parity 0; busy 13 cycles. Macro undefined: 12-bit frames, no parity bit.
